icache_fetch: RTL and testbench
===============================

# icache_fetch

Parametrised N-way set-associative instruction cache with integrated fetch handshake. It sits between the PC/fetch-request stage and the instruction memory port. It returns one 32-bit instruction per accepted request. Misses are refilled over a multi-beat valid/ready memory interface, replacing the single-cycle whole-line memory read. It adds a configurable number of ways, round-robin replacement, a flush for fence.i, and misalignment reporting.

## Interface
- ADDR_W, 64, fetch address width
- SETS, 256, number of sets; power of two
- WAYS, 2, associativity; ≥1
- LINE_BYTES, 16, line size; power of two, ≥4
- MEM_W, 32, refill beat width; LINE_BYTES*8 must be a multiple of MEM_W, and MEM_W ≥ 32
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  fetch request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_pc  in  ADDR_W  fetch address
- rsp_valid  out  1  response present; held until rsp_ready
- rsp_ready  in  1  consumer accepts response
- rsp_instr  out  32  instruction word; 0 on misalign
- rsp_misalign  out  1  req_pc[1:0] != 0
- flush  in  1  invalidate all lines (one-cycle pulse is sufficient)
- mem_req_valid  out  1  line refill request
- mem_req_ready  in  1  memory accepts the request
- mem_req_addr  out  ADDR_W  line-aligned address (offset bits = 0)
- mem_rsp_valid  in  1  refill beat present
- mem_rsp_data  in  MEM_W  refill beat; lowest address first
- stat_hits, stat_misses  out  32 each  wrapping event counters

## Operation
- Address split: offset = low log2(LINE_BYTES) bits; index = next log2(SETS) bits; tag = remainder. Word select = offset[..:2].
- Storage per set/way: valid bit, tag, line. Per set: round-robin victim pointer, log2(WAYS) bits, wrapping.
- FSM states: IDLE, MISS_REQ, REFILL, RESP.
- IDLE: req_ready = 1 iff no response is pending and no flush is pending or asserted.
- On accept, if pc[1:0] != 0: go to RESP with rsp_misalign = 1 and rsp_instr = 0. No lookup, no counter change.
- On accept, hit (valid && tag match in any way; at most one way can match): go to RESP with the selected word; stat_hits += 1.
- On accept, miss: latch pc; go to MISS_REQ; stat_misses += 1.
- MISS_REQ: mem_req_valid = 1, mem_req_addr = line address. On mem_req_ready go to REFILL with beat counter = 0.
- REFILL: each mem_rsp_valid writes beat k into line bits [k*MEM_W +: MEM_W]. After beat BEATS-1 (BEATS = LINE_BYTES*8/MEM_W):
  - install the line in the victim way: lowest-index invalid way, else the set's RR pointer;
  - the RR pointer advances only when a valid line is evicted;
  - go to RESP with the requested word.
- mem_rsp_valid outside REFILL is ignored.
- RESP: rsp_valid = 1; outputs stable until rsp_ready; then go to IDLE.
- Flush in IDLE: all valid bits and RR pointers clear at the next edge; a request in the same cycle is not accepted.
- Flush in any other state: latched as pending. The in-flight miss completes and is answered. The flush is applied on the cycle of return to IDLE, before any new accept.

## Timing
- Reset values: req_ready 0 while rst is high, then 1; rsp_valid, rsp_misalign, mem_req_valid 0; rsp_instr, mem_req_addr 0; counters 0; all valid bits 0; RR pointers 0; flush-pending 0.
- Reset mid-refill aborts the refill: state goes to IDLE, nothing is installed, no response is issued.
- Hit: accept at edge T; rsp_valid high after T+1; req_ready low until the response is consumed. Back-to-back hits run at one response per 2 cycles.
- Miss: mem_req_valid high in the cycle after accept. Installed line and rsp_valid appear at the edge after the final beat, so minimum miss latency = 2 + BEATS cycles.
- A request that follows a refill of the same line hits.
- Counters wrap from 0xFFFFFFFF to 0.

## Test plan
- Cold miss then hit:
  - fetch 0x8000_0004 with memory words 0x11,0x22,0x33,0x44 at 0x8000_0000..C; expect mem_req_addr 0x8000_0000, 4 beats, rsp_instr 0x22, stat_misses 1;
  - refetch 0x8000_000C; expect rsp_instr 0x44 one cycle after accept, stat_hits 1, no mem_req_valid.
- Replacement, WAYS=2, SETS=256: fetch 0x0000, 0x1000, 0x2000 (same set, three tags).
  - third fill evicts way 0;
  - 0x1000 still hits; 0x0000 misses.
- Backpressure: hold rsp_ready=0 for 5 cycles on a hit; rsp_valid and rsp_instr stay stable, req_ready stays 0. Stall mem_req_ready 3 cycles; mem_req_addr stays stable.
- Misalign: fetch 0x8000_0002; expect rsp_misalign 1, rsp_instr 0, no memory request, counters unchanged.
- Flush: pulse flush during REFILL of 0x8000_0000.
  - response is still 0x11;
  - the next fetch of 0x8000_0000 misses;
  - flush and req_valid together in IDLE: req_ready 0 that cycle.
- Reset mid-refill: assert rst after 2 beats, then drive stray mem_rsp_valid. No response issued, state IDLE, and the next fetch of the same line misses.

Source files
------------

// File: rtl/icache_fetch.sv
// N-way set-associative instruction cache with fetch handshake, multi-beat
// line refill, round-robin replacement, fence.i flush and misalign reporting.
module icache_fetch #(
    parameter int unsigned ADDR_W     = 64,
    parameter int unsigned SETS       = 256,
    parameter int unsigned WAYS       = 2,
    parameter int unsigned LINE_BYTES = 16,
    parameter int unsigned MEM_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_pc,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_instr,
    output logic              rsp_misalign,
    input  logic              flush,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [MEM_W-1:0]  mem_rsp_data,
    output logic [31:0]       stat_hits,
    output logic [31:0]       stat_misses
);

    localparam int unsigned OFF_W  = $clog2(LINE_BYTES);
    localparam int unsigned IDX_W  = $clog2(SETS);
    localparam int unsigned TAG_W  = ADDR_W - OFF_W - IDX_W;
    localparam int unsigned LINE_W = LINE_BYTES * 8;
    localparam int unsigned BEATS  = LINE_W / MEM_W;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int unsigned WS_W   = (OFF_W > 2) ? OFF_W - 2 : 1;

    typedef enum logic [1:0] {IDLE, MISS_REQ, REFILL, RESP} state_t;

    state_t state, state_n;

    logic [WAYS-1:0]   valid_q [SETS];
    logic [WAY_W-1:0]  rr_q    [SETS];
    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    logic [LINE_W-1:0] data_q  [SETS][WAYS];

    logic [ADDR_W-1:2] pc_q;
    logic [BEAT_W-1:0] beat_q;
    logic [LINE_W-1:0] line_buf;
    logic              flush_pend;

    logic [IDX_W-1:0]  req_idx, fill_idx;
    logic [TAG_W-1:0]  req_tag, fill_tag;
    logic [WS_W-1:0]   req_ws, fill_ws;
    logic              misalign, hit, set_full;
    logic [31:0]       hit_word, fill_word;
    logic [WAY_W-1:0]  victim;
    logic [LINE_W-1:0] line_next;
    logic              accept, do_flush, fill;

    assign req_idx  = req_pc[OFF_W +: IDX_W];
    assign req_tag  = req_pc[ADDR_W-1 -: TAG_W];
    assign fill_idx = pc_q[OFF_W +: IDX_W];
    assign fill_tag = pc_q[ADDR_W-1 -: TAG_W];
    assign misalign = (req_pc[1:0] != 2'b00);

    // Word select within a line; a one-word line has no select bits.
    if (OFF_W > 2) begin : g_ws
        assign req_ws  = req_pc[OFF_W-1:2];
        assign fill_ws = pc_q[OFF_W-1:2];
    end else begin : g_ws_none
        assign req_ws  = '0;
        assign fill_ws = '0;
    end

    // Tag lookup across all ways; at most one way matches.
    always_comb begin
        hit      = 1'b0;
        hit_word = '0;
        for (int w = 0; w < int'(WAYS); w++) begin
            if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
                hit      = 1'b1;
                hit_word = data_q[req_idx][w][32*req_ws +: 32];
            end
        end
    end

    // Victim: lowest-index invalid way, otherwise the set's round-robin pointer.
    always_comb begin
        victim   = rr_q[fill_idx];
        set_full = 1'b1;
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (!valid_q[fill_idx][w]) begin
                victim   = WAY_W'(w);
                set_full = 1'b0;
            end
        end
    end

    always_comb begin
        line_next = line_buf;
        line_next[MEM_W*beat_q +: MEM_W] = mem_rsp_data;
        fill_word = line_next[32*fill_ws +: 32];
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        req_ready = 1'b0;
        accept    = 1'b0;
        do_flush  = 1'b0;
        fill      = 1'b0;
        case (state)
            IDLE: begin
                do_flush  = flush || flush_pend;
                req_ready = !do_flush && !rst;
                accept    = req_valid && req_ready;
                if (accept) state_n = (misalign || hit) ? RESP : MISS_REQ;
            end
            MISS_REQ: if (mem_req_ready) state_n = REFILL;
            REFILL: begin
                if (mem_rsp_valid && (beat_q == BEAT_W'(BEATS - 1)) && !rst) begin
                    fill    = 1'b1;
                    state_n = RESP;
                end
            end
            RESP: if (rsp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Response, memory request, counters and refill assembly.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid     <= 1'b0;
            rsp_instr     <= '0;
            rsp_misalign  <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            stat_hits     <= '0;
            stat_misses   <= '0;
            flush_pend    <= 1'b0;
            pc_q          <= '0;
            beat_q        <= '0;
            line_buf      <= '0;
        end else begin
            rsp_valid     <= (state_n == RESP);
            mem_req_valid <= (state_n == MISS_REQ);
            if (state == IDLE) flush_pend <= 1'b0;
            else if (flush)    flush_pend <= 1'b1;
            if (accept) begin
                pc_q         <= req_pc[ADDR_W-1:2];
                rsp_misalign <= misalign;
                if (misalign) begin
                    rsp_instr <= '0;
                end else if (hit) begin
                    rsp_instr <= hit_word;
                    stat_hits <= stat_hits + 32'd1;
                end else begin
                    stat_misses  <= stat_misses + 32'd1;
                    mem_req_addr <= {req_pc[ADDR_W-1:OFF_W], OFF_W'(0)};
                end
            end
            if ((state == MISS_REQ) && mem_req_ready) beat_q <= '0;
            if ((state == REFILL) && mem_rsp_valid) begin
                line_buf <= line_next;
                beat_q   <= beat_q + 1'b1;
            end
            if (fill) rsp_instr <= fill_word;
        end
    end

    // Valid bits and replacement pointers; flush clears both.
    always_ff @(posedge clk) begin
        if (rst || do_flush) begin
            for (int s = 0; s < int'(SETS); s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else if (fill) begin
            valid_q[fill_idx][victim] <= 1'b1;
            if (set_full)
                rr_q[fill_idx] <= (rr_q[fill_idx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[fill_idx] + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill) begin
            tag_q[fill_idx][victim]  <= fill_tag;
            data_q[fill_idx][victim] <= line_next;
        end
    end

endmodule

// File: tb/tb_icache_fetch.sv
// Scoreboard bench for icache_fetch: directed fetches against a memory
// responder, with a negedge monitor comparing responses to queued expectations.
module tb_icache_fetch;

    localparam int unsigned ADDR_W = 64;
    localparam int unsigned MEM_W  = 32;
    localparam int BEATS = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [ADDR_W-1:0] req_pc = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [31:0]       rsp_instr;
    logic              rsp_misalign;
    logic              flush = 1'b0;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_rsp_valid;
    logic [MEM_W-1:0]  mem_rsp_data;
    logic [31:0]       stat_hits;
    logic [31:0]       stat_misses;

    always #5 clk = ~clk;

    icache_fetch #(
        .ADDR_W(64), .SETS(256), .WAYS(2), .LINE_BYTES(16), .MEM_W(32)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr),
        .rsp_misalign(rsp_misalign), .flush(flush),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data(mem_rsp_data),
        .stat_hits(stat_hits), .stat_misses(stat_misses)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic        mis;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0, failures = 0;
    int          n_rsp = 0, n_pushed = 0, n_mem_req = 0, beats_sent = 0;
    int          mem_stall = 0, beat_limit = BEATS, stray_req = 0;
    logic [63:0] exp_mem_addr = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, expv);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        case (a)
            64'h8000_0000: return 32'h11;
            64'h8000_0004: return 32'h22;
            64'h8000_0008: return 32'h33;
            64'h8000_000C: return 32'h44;
            default:       return a[31:0] ^ 32'hCAFE_0000;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Response monitor: pops one expectation per handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_instr", 64'(rsp_instr), 64'(e.instr));
                    chk("rsp_misalign", 64'(rsp_misalign), 64'(e.mis));
                end
                n_rsp++;
            end
        end
    end

    // Memory responder: optional request stall, limited beats, stray beats when idle.
    initial begin
        logic [63:0] a;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        forever begin
            step();
            if (!rst && mem_req_valid) begin
                a = mem_req_addr;
                n_mem_req++;
                chk("mem_req_addr", a, exp_mem_addr);
                for (int s = 0; s < mem_stall; s++) begin
                    step();
                    chk("stall_req_valid", 64'(mem_req_valid), 64'd1);
                    chk("stall_req_addr", mem_req_addr, a);
                end
                mem_req_ready = 1'b1;
                step();
                mem_req_ready = 1'b0;
                for (int b = 0; b < beat_limit; b++) begin
                    mem_rsp_valid = 1'b1;
                    mem_rsp_data  = mem_word(a + 64'(4 * b));
                    beats_sent++;
                    step();
                end
                mem_rsp_valid = 1'b0;
                mem_rsp_data  = '0;
            end else if (stray_req > 0) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = 32'hDEAD_BEEF;
                stray_req--;
            end else begin
                mem_rsp_valid = 1'b0;
            end
        end
    end

    task automatic fetch(input logic [63:0] pc, input logic [31:0] instr, input logic mis, input bit push);
        int cnt;
        bit ok;
        exp_t e;
        cnt = 0;
        ok  = 1'b0;
        if (push) begin
            e.instr = instr;
            e.mis   = mis;
            exp_q.push_back(e);
            n_pushed++;
        end
        req_valid = 1'b1;
        req_pc    = pc;
        while (!ok && cnt < 50) begin
            #1;
            if (req_ready) ok = 1'b1;
            @(posedge clk);
            #1;
            cnt++;
        end
        req_valid = 1'b0;
        chk("accept_timeout", 64'(ok), 64'd1);
    endtask

    task automatic wait_rsp();
        int cnt;
        cnt = 0;
        while (n_rsp < n_pushed && cnt < 200) begin
            step();
            cnt++;
        end
        chk("rsp_timeout", 64'(n_rsp), 64'(n_pushed));
    endtask

    task automatic chk_stats(input string name, input int eh, input int em);
        chk({name, "_hits"}, 64'(stat_hits), 64'(eh));
        chk({name, "_misses"}, 64'(stat_misses), 64'(em));
    endtask

    initial begin
        int eh, em, base, bs, cnt;
        eh = 0;
        em = 0;
        repeat (3) step();
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        rst = 1'b0;
        #1;
        chk("rst_req_ready_after", 64'(req_ready), 64'd1);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_misalign", 64'(rsp_misalign), 64'd0);
        chk("rst_rsp_instr", 64'(rsp_instr), 64'd0);
        chk("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
        chk("rst_mem_req_addr", mem_req_addr, 64'd0);
        chk_stats("rst", 0, 0);

        // Cold miss, then hit on the same line.
        exp_mem_addr = 64'h8000_0000;
        fetch(64'h8000_0004, 32'h22, 1'b0, 1'b1);
        chk("miss_mem_req_next_cycle", 64'(mem_req_valid), 64'd1);
        chk("miss_no_early_rsp", 64'(rsp_valid), 64'd0);
        wait_rsp();
        em++;
        chk_stats("cold_miss", eh, em);
        chk("cold_miss_mem_reqs", 64'(n_mem_req), 64'd1);

        base = n_mem_req;
        fetch(64'h8000_000C, 32'h44, 1'b0, 1'b1);
        chk("hit_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("hit_rsp_instr", 64'(rsp_instr), 64'h44);
        chk("hit_no_mem_req", 64'(mem_req_valid), 64'd0);
        wait_rsp();
        eh++;
        chk_stats("hit", eh, em);
        chk("hit_mem_reqs", 64'(n_mem_req), 64'(base));

        // Response backpressure on a hit.
        rsp_ready = 1'b0;
        fetch(64'h8000_0008, 32'h33, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("bp_rsp_instr", 64'(rsp_instr), 64'h33);
            chk("bp_req_ready", 64'(req_ready), 64'd0);
            step();
        end
        rsp_ready = 1'b1;
        wait_rsp();
        eh++;

        // Misaligned fetch.
        base = n_mem_req;
        fetch(64'h8000_0002, 32'h0, 1'b1, 1'b1);
        wait_rsp();
        repeat (2) step();
        chk("misalign_mem_reqs", 64'(n_mem_req), 64'(base));
        chk_stats("misalign", eh, em);

        // Flush together with a request in IDLE.
        flush     = 1'b1;
        req_valid = 1'b1;
        req_pc    = 64'h8000_000C;
        #1;
        chk("flush_idle_req_ready", 64'(req_ready), 64'd0);
        step();
        flush     = 1'b0;
        req_valid = 1'b0;
        chk("flush_idle_no_rsp", 64'(rsp_valid), 64'd0);
        chk("flush_idle_no_mem", 64'(mem_req_valid), 64'd0);
        base = n_mem_req;
        fetch(64'h8000_000C, 32'h44, 1'b0, 1'b1);
        chk("flush_idle_refetch_miss", 64'(mem_req_valid), 64'd1);
        wait_rsp();
        em++;
        chk("flush_idle_mem_reqs", 64'(n_mem_req), 64'(base + 1));
        flush = 1'b1;
        step();
        flush = 1'b0;

        // Replacement in set 0 with three tags; first refill stalls the request.
        mem_stall    = 3;
        exp_mem_addr = 64'h0;
        fetch(64'h0, 32'hCAFE_0000, 1'b0, 1'b1);
        wait_rsp();
        em++;
        mem_stall    = 0;
        exp_mem_addr = 64'h1000;
        fetch(64'h1000, 32'hCAFE_1000, 1'b0, 1'b1);
        wait_rsp();
        em++;
        exp_mem_addr = 64'h2000;
        fetch(64'h2000, 32'hCAFE_2000, 1'b0, 1'b1);
        wait_rsp();
        em++;
        base = n_mem_req;
        fetch(64'h1000, 32'hCAFE_1000, 1'b0, 1'b1);
        wait_rsp();
        eh++;
        chk("repl_way1_kept", 64'(n_mem_req), 64'(base));
        exp_mem_addr = 64'h0;
        fetch(64'h0, 32'hCAFE_0000, 1'b0, 1'b1);
        wait_rsp();
        em++;
        chk("repl_way0_evicted", 64'(n_mem_req), 64'(base + 1));
        base = n_mem_req;
        fetch(64'h2000, 32'hCAFE_2000, 1'b0, 1'b1);
        wait_rsp();
        eh++;
        chk("repl_third_line_hits", 64'(n_mem_req), 64'(base));
        chk_stats("repl", eh, em);

        // Flush pulsed during refill: in-flight miss still answered.
        exp_mem_addr = 64'h8000_0000;
        fetch(64'h8000_0000, 32'h11, 1'b0, 1'b1);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        wait_rsp();
        em++;
        base = n_mem_req;
        fetch(64'h8000_0000, 32'h11, 1'b0, 1'b1);
        wait_rsp();
        em++;
        chk("flush_pending_applied", 64'(n_mem_req), 64'(base + 1));
        chk_stats("flush_refill", eh, em);

        // Reset after two refill beats, then stray beats while idle.
        exp_mem_addr = 64'h40;
        beat_limit   = 2;
        bs           = beats_sent;
        fetch(64'h40, 32'h0, 1'b0, 1'b0);
        cnt = 0;
        while (beats_sent < bs + 2 && cnt < 50) begin
            step();
            cnt++;
        end
        chk("abort_beats_timeout", 64'(beats_sent), 64'(bs + 2));
        step();
        rst = 1'b1;
        step();
        rst        = 1'b0;
        beat_limit = BEATS;
        eh         = 0;
        em         = 0;
        stray_req  = 3;
        base       = n_mem_req;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("abort_no_rsp", 64'(rsp_valid), 64'd0);
            chk("abort_idle_ready", 64'(req_ready), 64'd1);
        end
        chk("abort_no_mem_req", 64'(n_mem_req), 64'(base));
        chk_stats("abort", eh, em);
        exp_mem_addr = 64'h40;
        fetch(64'h40, 32'hCAFE_0040, 1'b0, 1'b1);
        wait_rsp();
        em++;
        chk("abort_refetch_miss", 64'(n_mem_req), 64'(base + 1));
        chk_stats("abort_refetch", eh, em);

        repeat (3) step();
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
